// File: rtl/data_bus_interconnect_if.sv
// Data-port bus bundle between the CPU master, the interconnect and its slaves.
// "slave" is the interconnect's view; "master" is the surrounding environment (CPU plus devices).
interface data_bus_interconnect_if #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                             m_req;
  logic                             m_we;
  logic [ADDR_WIDTH-1:0]            m_addr;
  logic [DATA_WIDTH-1:0]            m_wdata;
  logic [DATA_WIDTH/8-1:0]          m_wstrb;
  logic                             m_ready;
  logic                             m_rvalid;
  logic [DATA_WIDTH-1:0]            m_rdata;
  logic                             m_err;
  logic [ADDR_WIDTH-1:0]            err_addr;
  logic [NUM_SLAVES-1:0]            s_req;
  logic                             s_we;
  logic [ADDR_WIDTH-1:0]            s_addr;
  logic [DATA_WIDTH-1:0]            s_wdata;
  logic [DATA_WIDTH/8-1:0]          s_wstrb;
  logic [NUM_SLAVES-1:0]            s_ack;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_wstrb, s_ack, s_rdata,
    output m_ready, m_rvalid, m_rdata, m_err, err_addr,
           s_req, s_we, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_wstrb, s_ack, s_rdata,
    input  m_ready, m_rvalid, m_rdata, m_err, err_addr,
           s_req, s_we, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/data_bus_interconnect.sv
// Routes one CPU data-port master to NUM_SLAVES address-decoded slaves with a registered
// request/ack handshake, byte strobes, unmapped-address errors and a per-transaction timeout.
module data_bus_interconnect #(
  parameter int                               NUM_SLAVES     = 3,
  parameter int                               ADDR_WIDTH     = 32,
  parameter int                               DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE     = {32'h9000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK     = {3{32'hFFFF_FF00}},
  parameter int                               TIMEOUT_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst,
  data_bus_interconnect_if.slave bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, RESP_ERR} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, dec_idx;
  logic                  dec_hit;
  logic                  accept, sel_ack, timeout;
  logic                  s_we_q;
  logic [ADDR_WIDTH-1:0] s_addr_q, err_addr_q;
  logic [DATA_WIDTH-1:0] s_wdata_q, rdata_q;
  logic [STRB_W-1:0]     s_wstrb_q;

  // Walk from the top index down so the lowest matching slave is the one left selected.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  assign accept  = (state_q == IDLE) && bus.m_req;
  assign sel_ack = bus.s_ack[idx_q];
  // The counter is 0 in the first BUSY cycle, so TIMEOUT_CYCLES-1 marks the last cycle s_req is held.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.m_req) state_d = dec_hit ? BUSY : RESP_ERR;
      end
      BUSY: begin
        if (sel_ack)      state_d = RESP;
        else if (timeout) state_d = RESP_ERR;
        else              cnt_d   = cnt_q + CNT_W'(1);
      end
      RESP, RESP_ERR: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && dec_hit) begin
        idx_q     <= dec_idx;
        s_we_q    <= bus.m_we;
        s_addr_q  <= bus.m_addr;
        s_wdata_q <= bus.m_wdata;
        s_wstrb_q <= bus.m_wstrb;
      end
      if (state_q == BUSY && sel_ack)
        rdata_q <= s_we_q ? '0 : bus.s_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
      if (accept && !dec_hit)
        err_addr_q <= bus.m_addr;
      else if (state_q == BUSY && !sel_ack && timeout)
        err_addr_q <= s_addr_q;
    end
  end

  assign bus.m_ready  = (state_q == IDLE);
  assign bus.m_rvalid = (state_q == RESP) || (state_q == RESP_ERR);
  assign bus.m_err    = (state_q == RESP_ERR);
  assign bus.m_rdata  = (state_q == RESP) ? rdata_q : '0;
  assign bus.err_addr = err_addr_q;
  assign bus.s_req    = (state_q == BUSY) ? (NUM_SLAVES'(1) << idx_q) : '0;
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wstrb  = s_wstrb_q;

endmodule
